hazard_controller: RTL and testbench

//  Pipeline interlock and flush sequencer for the decode/operand-fetch (DOF) stage.
//  - Keeps a per-register scoreboard of in-flight writes.
//  - Stalls IF/DOF when a decoded source register is still pending.
//  - Sequences a 2-cycle flush after a taken branch resolves in EX.
//  - Sits between the instruction register and the DOF pipeline register; drives PC hold and DOF bubble.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_scoreboard.sv | 52 +++++
 rtl/hazard_controller.sv | 114 +++++++++++
 tb/tb_hazard_controller.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the DOF-stage hazard controller.
// The optional forwarding mode is enabled by defining HAZARD_FWD_EN.
package hazard_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_WB_LATENCY     = 2;
  localparam int DEF_CNT_WIDTH      = 16;

  // Pending counters hold 0..WB_LATENCY, and WB_LATENCY is at most 3.
  localparam int PEND_WIDTH = 2;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FLUSH1 = 1'b1
  } flush_state_e;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_WB      = 2'd1;
  localparam logic [1:0] FWD_EX      = 2'd2;
  localparam logic [1:0] FWD_MEM     = 2'd3;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard of in-flight writes: a countdown to writeback
// plus a load flag for each register, with two combinational read ports.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int WB_LATENCY     = DEF_WB_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_set,
  input  logic [REG_ADDR_WIDTH-1:0] i_da,
  input  logic                      i_ld,
  input  logic [REG_ADDR_WIDTH-1:0] i_aa,
  input  logic [REG_ADDR_WIDTH-1:0] i_ba,
  output logic [PEND_WIDTH-1:0]     o_pend_a,
  output logic [PEND_WIDTH-1:0]     o_pend_b,
  output logic                      o_ld_a,
  output logic                      o_ld_b
);

  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
  localparam logic [PEND_WIDTH-1:0] PEND_INIT = PEND_WIDTH'(WB_LATENCY);

  logic [PEND_WIDTH-1:0] r_pend [NUM_REGS];
  logic                  r_ld   [NUM_REGS];

  // Entry 0 is never written, so R0 can never appear pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_pend[r] <= '0;
        r_ld[r]   <= 1'b0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (i_set && (i_da == REG_ADDR_WIDTH'(r))) begin
          r_pend[r] <= PEND_INIT;
          r_ld[r]   <= i_ld;
        end else if (r_pend[r] != '0) begin
          r_pend[r] <= r_pend[r] - 1'b1;
        end
      end
    end
  end

  assign o_pend_a = (i_aa == '0) ? '0 : r_pend[i_aa];
  assign o_pend_b = (i_ba == '0) ? '0 : r_pend[i_ba];
  assign o_ld_a   = (i_aa == '0) ? 1'b0 : r_ld[i_aa];
  assign o_ld_b   = (i_ba == '0) ? 1'b0 : r_ld[i_ba];

endmodule

// File: rtl/hazard_controller.sv
// DOF-stage interlock: scoreboard-driven stalls, 2-cycle branch flush, stall counter.
// Define HAZARD_FWD_EN to forward ALU results and stall only on load-use.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int WB_LATENCY     = DEF_WB_LATENCY,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_valid,
  input  logic [REG_ADDR_WIDTH-1:0] aa,
  input  logic [REG_ADDR_WIDTH-1:0] ba,
  input  logic                      use_a,
  input  logic                      use_b,
  input  logic                      rw_dec,
  input  logic [REG_ADDR_WIDTH-1:0] da_dec,
  input  logic                      ld_dec,
  input  logic                      branch_taken,
  output logic                      stall,
  output logic                      bubble,
  output logic                      flush,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b
);

  flush_state_e          r_state;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;

  logic                  w_issue;
  logic                  w_set;
  logic [PEND_WIDTH-1:0] w_pend_a;
  logic [PEND_WIDTH-1:0] w_pend_b;
  logic                  w_ld_a;
  logic                  w_ld_b;
  logic                  w_src_a;
  logic                  w_src_b;
  logic                  w_haz_a;
  logic                  w_haz_b;
  logic                  w_stall;
  logic                  w_flush;

  // Squashed or stalled instructions must not reserve their destination.
  assign w_issue = if_valid & ~w_stall & ~w_flush;
  assign w_set   = w_issue & rw_dec & (da_dec != '0);

  hazard_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .WB_LATENCY     (WB_LATENCY)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_set    (w_set),
    .i_da     (da_dec),
    .i_ld     (ld_dec),
    .i_aa     (aa),
    .i_ba     (ba),
    .o_pend_a (w_pend_a),
    .o_pend_b (w_pend_b),
    .o_ld_a   (w_ld_a),
    .o_ld_b   (w_ld_b)
  );

  assign w_src_a = use_a & (aa != '0);
  assign w_src_b = use_b & (ba != '0);

`ifdef HAZARD_FWD_EN
  // Only a load issued last cycle has no forwarding source yet.
  assign w_haz_a = w_src_a & w_ld_a & (w_pend_a == PEND_WIDTH'(WB_LATENCY));
  assign w_haz_b = w_src_b & w_ld_b & (w_pend_b == PEND_WIDTH'(WB_LATENCY));
  assign fwd_a   = w_src_a ? w_pend_a : FWD_REGFILE;
  assign fwd_b   = w_src_b ? w_pend_b : FWD_REGFILE;
`else
  logic w_unused_ld;
  assign w_unused_ld = w_ld_a ^ w_ld_b;
  assign w_haz_a = w_src_a & (w_pend_a != '0);
  assign w_haz_b = w_src_b & (w_pend_b != '0);
  assign fwd_a   = FWD_REGFILE;
  assign fwd_b   = FWD_REGFILE;
`endif

  // A branch kills the DOF slot this cycle and the IF slot next cycle.
  assign w_flush = (r_state == ST_FLUSH1) | branch_taken;
  assign w_stall = if_valid & (w_haz_a | w_haz_b) & ~w_flush;

  assign stall     = w_stall;
  assign flush     = w_flush;
  assign bubble    = w_stall | w_flush;
  assign stall_cnt = r_stall_cnt;

  // Branches seen during FLUSH1 are on the wrong path and are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:    if (branch_taken) r_state <= ST_FLUSH1;
        ST_FLUSH1: r_state <= ST_RUN;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller against a timestamp-based model.
// Works with or without HAZARD_FWD_EN defined.
module tb_hazard_controller;

  localparam int AW       = 5;
  localparam int LAT      = 2;
  localparam int CW       = 5;
  localparam int CNT_MAX  = (1 << CW) - 1;
  localparam int NREGS    = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_valid = 1'b0;
  logic [AW-1:0] aa = '0;
  logic [AW-1:0] ba = '0;
  logic          use_a = 1'b0;
  logic          use_b = 1'b0;
  logic          rw_dec = 1'b0;
  logic [AW-1:0] da_dec = '0;
  logic          ld_dec = 1'b0;
  logic          branch_taken = 1'b0;
  logic          stall;
  logic          bubble;
  logic          flush;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;

  int compared = 0;
  int mismatched = 0;

  int cyc = 0;
  int last_issue [NREGS];
  bit last_ld [NREGS];
  int flush2_cyc = -1;
  int cnt_model = 0;
  bit e_stall;
  bit e_flush;
  logic [6:0] exp_vec;
  logic [6:0] obs_vec;

  assign obs_vec = {stall, bubble, flush, fwd_a, fwd_b};

  hazard_controller #(
    .REG_ADDR_WIDTH (AW),
    .WB_LATENCY     (LAT),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .aa           (aa),
    .ba           (ba),
    .use_a        (use_a),
    .use_b        (use_b),
    .rw_dec       (rw_dec),
    .da_dec       (da_dec),
    .ld_dec       (ld_dec),
    .branch_taken (branch_taken),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .stall_cnt    (stall_cnt),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // A write issued in cycle t is outstanding in cycles t+1 .. t+LAT.
  function automatic int model_pend(input logic [AW-1:0] r);
    int age;
    if (r == '0) return 0;
    age = cyc - last_issue[r];
    if (age >= 1 && age <= LAT) return LAT - age + 1;
    return 0;
  endfunction

  function automatic bit model_load_use(input logic [AW-1:0] r);
    return (r != '0) && last_ld[r] && (cyc - last_issue[r] == 1);
  endfunction

  task automatic model_eval();
    int pa;
    int pb;
    bit ha;
    bit hb;
    logic [1:0] fa;
    logic [1:0] fb;
    pa = (use_a && aa != '0) ? model_pend(aa) : 0;
    pb = (use_b && ba != '0) ? model_pend(ba) : 0;
`ifdef HAZARD_FWD_EN
    ha = use_a && model_load_use(aa);
    hb = use_b && model_load_use(ba);
    fa = pa[1:0];
    fb = pb[1:0];
`else
    ha = (pa != 0);
    hb = (pb != 0);
    fa = 2'd0;
    fb = 2'd0;
`endif
    e_flush = (cyc == flush2_cyc) || branch_taken;
    e_stall = if_valid && (ha || hb) && !e_flush;
    exp_vec = {e_stall, e_stall | e_flush, e_flush, fa, fb};
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      last_issue[r] = -100;
      last_ld[r] = 1'b0;
    end
    flush2_cyc = -1;
    cnt_model = 0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (if_valid && !e_stall && !e_flush && rw_dec && da_dec != '0) begin
      last_issue[da_dec] = cyc;
      last_ld[da_dec] = ld_dec;
    end
    if (branch_taken && cyc != flush2_cyc) flush2_cyc = cyc + 1;
    if (e_stall && cnt_model < CNT_MAX) cnt_model++;
    cyc++;
    #1;
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input bit ua, input bit ub, input bit rw, input logic [AW-1:0] d,
                       input bit ld, input bit br);
    if_valid = v; aa = a; ba = b; use_a = ua; use_b = ub;
    rw_dec = rw; da_dec = d; ld_dec = ld; branch_taken = br;
    #2;
    model_eval();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (obs_vec !== 7'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", obs_vec, 7'd0);
    end
    compared++;
    if (stall_cnt !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_cnt got=%0d want=0", stall_cnt);
    end
    compared++;
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (obs_vec !== 7'd0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_outputs got=%b want=%b", obs_vec, 7'd0);
    end
    compared++;
    tick();
  endtask

  task automatic test_raw_stall();
    bit want;
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
    if (obs_vec !== exp_vec) begin
      mismatched++;
      $display("[TB] FAIL raw_issue got=%b want=%b", obs_vec, exp_vec);
    end
    compared++;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 0, 1, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
      want = 1'b0;
`else
      want = (i < 2);
`endif
      if (stall !== want || bubble !== want || obs_vec !== exp_vec) begin
        mismatched++;
        $display("[TB] FAIL raw_stall_c%0d got=%b want_stall=%b model=%b", i, obs_vec, want, exp_vec);
      end
      compared++;
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    if (stall_cnt !== CW'(0)) begin
      mismatched++;
      $display("[TB] FAIL raw_cnt got=%0d want=0", stall_cnt);
    end
`else
    if (stall_cnt !== CW'(2)) begin
      mismatched++;
      $display("[TB] FAIL raw_cnt got=%0d want=2", stall_cnt);
    end
`endif
    compared++;
  endtask

  task automatic test_r0();
    logic [AW-1:0] r;
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      r = AW'(i);
      drive(1, r, 0, 1, 1, 0, 0, 0, 0);
      if (stall !== 1'b0 || obs_vec !== exp_vec) begin
        mismatched++;
        $display("[TB] FAIL r0_read_r%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      compared++;
      tick();
    end
  endtask

  task automatic test_flush();
    logic [2:0] want;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1, 0, 0, 0, 0, 1, 4, 0, 1);
      else drive(1, 4, 0, 1, 0, 0, 0, 0, 0);
      want = (i < 2) ? 3'b011 : 3'b000;
      if ({stall, bubble, flush} !== want || obs_vec !== exp_vec) begin
        mismatched++;
        $display("[TB] FAIL flush_c%0d got=%b want_sbf=%b model=%b", i, obs_vec, want, exp_vec);
      end
      compared++;
      tick();
    end
  endtask

  task automatic test_flush_vs_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 0, 1, 0, 0, 0, 0, (i == 0));
      if (stall !== 1'b0 || flush !== (i < 2) || obs_vec !== exp_vec) begin
        mismatched++;
        $display("[TB] FAIL flush_beats_stall_c%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      compared++;
      tick();
    end
  endtask

  task automatic test_forward();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 7, 0, 1, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
      if (stall !== 1'b0 || fwd_b !== 2'(2 - i)) begin
        mismatched++;
        $display("[TB] FAIL fwd_alu_c%0d got stall=%b fwd_b=%0d want stall=0 fwd_b=%0d", i, stall, fwd_b, 2 - i);
      end
      compared++;
`endif
      if (obs_vec !== exp_vec) begin
        mismatched++;
        $display("[TB] FAIL fwd_alu_model_c%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      compared++;
      tick();
    end
    drive(1, 0, 0, 0, 0, 1, 7, 1, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 7, 0, 1, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
      if (stall !== (i == 0)) begin
        mismatched++;
        $display("[TB] FAIL load_use_c%0d got stall=%b want=%b", i, stall, (i == 0));
      end
      compared++;
`endif
      if (obs_vec !== exp_vec) begin
        mismatched++;
        $display("[TB] FAIL load_use_model_c%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      compared++;
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 2) != 0),
            AW'($urandom_range(0, 7)), $urandom_range(0, 1), ($urandom_range(0, 11) == 0));
      if (obs_vec !== exp_vec) begin
        mismatched++;
        $display("[TB] FAIL random_c%0d got=%b want=%b", i, obs_vec, exp_vec);
      end
      compared++;
      tick();
      if (stall_cnt !== CW'(cnt_model)) begin
        mismatched++;
        $display("[TB] FAIL random_cnt_c%0d got=%0d want=%0d", i, stall_cnt, cnt_model);
      end
      compared++;
    end
  endtask

  task automatic test_saturation();
    int stalls;
    int budget;
    do_reset();
    stalls = 0;
    budget = 0;
    while (stalls < CNT_MAX + 4 && budget < 200) begin
      drive(1, 5, 0, 1, 0, 1, 5, 1, 0);
      if (obs_vec !== exp_vec) begin
        mismatched++;
        $display("[TB] FAIL sat_c%0d got=%b want=%b", budget, obs_vec, exp_vec);
      end
      compared++;
      if (stall === 1'b1) stalls++;
      tick();
      budget++;
    end
    if (stalls < CNT_MAX + 4) begin
      mismatched++;
      $display("[TB] FAIL sat_budget got=%0d stalls want=%0d", stalls, CNT_MAX + 4);
    end
    compared++;
    if (stall_cnt !== CW'(CNT_MAX) || cnt_model != CNT_MAX) begin
      mismatched++;
      $display("[TB] FAIL sat_cnt got=%0d want=%0d", stall_cnt, CNT_MAX);
    end
    compared++;
  endtask

  task automatic test_reset_mid_flush();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    if (flush !== 1'b1 || stall_cnt !== CW'(CNT_MAX)) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_flush got flush=%b cnt=%0d want flush=1 cnt=%0d", flush, stall_cnt, CNT_MAX);
    end
    compared++;
    rst_n = 1'b0;
    #1;
    if (flush !== 1'b0 || bubble !== 1'b0 || stall_cnt !== '0) begin
      mismatched++;
      $display("[TB] FAIL async_reset got flush=%b bubble=%b cnt=%0d want 0 0 0", flush, bubble, stall_cnt);
    end
    compared++;
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    if (obs_vec !== 7'd0) begin
      mismatched++;
      $display("[TB] FAIL after_async_reset got=%b want=%b", obs_vec, 7'd0);
    end
    compared++;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_raw_stall();
    test_r0();
    test_flush();
    test_flush_vs_stall();
    test_forward();
    test_random();
    test_saturation();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
